vram_fetch: RTL and testbench

Video-memory fetch stage that sits directly upstream of the Vector-06C display block. It watches the 13-bit column/row address the display presents, reads the four 8 KB bit-planes for that address from a shared byte-wide memory port using a req/ack handshake, and delivers the assembled 32-bit plane word on `vdata`. `vdata` is double-buffered, so the display only ever sees a complete, coherent 4-plane word.

---
 rtl/vector_video_pkg.sv | 25 ++
 rtl/vram_fetch_if.sv | 25 ++
 rtl/vram_fetch_stats.sv | 33 +++
 rtl/vram_fetch.sv | 158 +++++++++++++++
 tb/tb_vram_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_video_pkg.sv
// Shared types and constants for the Vector-06C video path: the fetch FSM
// state encoding, address/plane geometry and the plane address formatter.
package vector_video_pkg;

  localparam int VADDR_W    = 13;
  localparam int PLANES     = 4;
  localparam int WORD_W     = PLANES * 8;
  localparam int MEM_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    COMMIT = 2'd2
  } vf_state_t;

  // Each bit-plane is an 8 KB window selected by the plane index.
  function automatic logic [MEM_ADDR_W-1:0] plane_addr(
    input logic [1:0]         base,
    input logic [1:0]         plane,
    input logic [VADDR_W-1:0] addr
  );
    return {base, plane, addr};
  endfunction

endpackage

// File: rtl/vram_fetch_if.sv
// Byte-wide shared memory read port with req/ack handshake; the fetch stage
// is the master, the memory arbiter the slave.
interface vram_fetch_if;
  import vector_video_pkg::*;

  logic                  mem_req;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_dout;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_dout
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_dout
  );

endinterface

// File: rtl/vram_fetch_stats.sv
// Saturating 16-bit counter of late address changes with synchronous clear;
// only instantiated when VRAM_FETCH_STATS_EN is defined.
module vram_fetch_stats (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'h0000;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vram_fetch.sv
// Fetches the four bit-planes for the display address over a byte-wide
// req/ack port and presents a double-buffered 32-bit plane word.
// Optional late-change statistics counter: define VRAM_FETCH_STATS_EN.
module vram_fetch
  import vector_video_pkg::*;
#(
  parameter logic [1:0] PLANE_BASE = 2'b00
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               fetch_en,
  input  logic [VADDR_W-1:0] vaddr,
  output logic [WORD_W-1:0]  vdata,
  output logic               vdata_valid,
  output logic               fetch_late,
`ifdef VRAM_FETCH_STATS_EN
  input  logic               late_clr,
  output logic [15:0]        late_count,
`endif
  vram_fetch_if.master       mem
);

  vf_state_t             state_q, state_d;
  logic [VADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic                  stale_q, stale_d;
  logic [1:0]            plane_q, plane_d;
  logic                  restart_q, restart_d;
  logic                  mem_req_q, mem_req_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]     vdata_q, vdata_d;
  logic                  vdata_valid_q, vdata_valid_d;
  logic                  fetch_late_q, fetch_late_d;
  logic [WORD_W-1:0]     asm_q, asm_d;
  logic                  addr_diff;

  assign addr_diff = (vaddr != cur_addr_q);

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    stale_d       = stale_q;
    plane_d       = plane_q;
    restart_d     = restart_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    vdata_d       = vdata_q;
    vdata_valid_d = 1'b0;
    fetch_late_d  = 1'b0;
    asm_d         = asm_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_en && (stale_q || addr_diff)) begin
          cur_addr_d = vaddr;
          stale_d    = 1'b0;
          plane_d    = 2'd0;
          restart_d  = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = plane_addr(PLANE_BASE, 2'd0, vaddr);
          state_d    = READ;
        end
      end

      READ: begin
        if (addr_diff && !restart_q) begin
          fetch_late_d = 1'b1;
          restart_d    = 1'b1;
        end
        if (mem_req_q) begin
          // The handshake is only ever closed by the ack, never withdrawn.
          if (mem.mem_ack) begin
            asm_d[{~plane_q, 3'b000} +: 8] = mem.mem_dout;
            mem_req_d = 1'b0;
            if (!fetch_en) begin
              stale_d   = 1'b1;
              restart_d = 1'b0;
              state_d   = IDLE;
            end else if (restart_q || addr_diff) begin
              // An address change seen on the ack cycle itself restarts at once.
              restart_d  = 1'b0;
              cur_addr_d = vaddr;
              plane_d    = 2'd0;
            end else if (plane_q == 2'(PLANES - 1)) begin
              state_d = COMMIT;
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end
        end else if (!fetch_en) begin
          stale_d   = 1'b1;
          restart_d = 1'b0;
          state_d   = IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = plane_addr(PLANE_BASE, plane_q, cur_addr_q);
        end
      end

      COMMIT: begin
        vdata_d       = asm_q;
        vdata_valid_d = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      stale_q       <= 1'b1;
      plane_q       <= 2'd0;
      restart_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      vdata_q       <= '0;
      vdata_valid_q <= 1'b0;
      fetch_late_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      stale_q       <= stale_d;
      plane_q       <= plane_d;
      restart_q     <= restart_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      vdata_q       <= vdata_d;
      vdata_valid_q <= vdata_valid_d;
      fetch_late_q  <= fetch_late_d;
    end
  end

  // Assembly bytes are always fully rewritten before a commit.
  always_ff @(posedge clk_sys) begin
    asm_q <= asm_d;
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign vdata        = vdata_q;
  assign vdata_valid  = vdata_valid_q;
  assign fetch_late   = fetch_late_q;

`ifdef VRAM_FETCH_STATS_EN
  vram_fetch_stats u_stats (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .inc     (fetch_late_q),
    .clr     (late_clr),
    .count   (late_count)
  );
`endif

endmodule

// File: tb/tb_vram_fetch.sv
// Self-checking bench for vram_fetch: randomized fetches with a plane-memory
// responder of variable ack latency and a word/address-level reference model.
module tb_vram_fetch;
  import vector_video_pkg::*;

  localparam logic [1:0] PB = 2'b00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [12:0] vaddr;
  logic [31:0] vdata;
  logic        vdata_valid;
  logic        fetch_late;
`ifdef VRAM_FETCH_STATS_EN
  logic        late_clr;
  logic [15:0] late_count;
`endif

  vram_fetch_if mem_if ();

  vram_fetch #(.PLANE_BASE(PB)) dut (
    .clk_sys     (clk),
    .reset_n     (reset_n),
    .fetch_en    (fetch_en),
    .vaddr       (vaddr),
    .vdata       (vdata),
    .vdata_valid (vdata_valid),
    .fetch_late  (fetch_late),
`ifdef VRAM_FETCH_STATS_EN
    .late_clr    (late_clr),
    .late_count  (late_count),
`endif
    .mem         (mem_if.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int viol     = 0;
  int glitch   = 0;
  int late_seen = 0;
  bit spur_en  = 1'b0;
  logic [16:0] req_log[$];
  logic [16:0] exp_log[$];
  logic [31:0] commits[$];
  logic [12:0] cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents: a distinct byte per plane and address.
  function automatic logic [7:0] byte_at(input int p, input logic [12:0] a);
    logic [7:0] b;
    b = 8'(17 * (p + 1));
    return b ^ a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [12:0] a);
    logic [31:0] w;
    w = '0;
    for (int p = 0; p < PLANES; p++) w[31-8*p -: 8] = byte_at(p, a);
    return w;
  endfunction

  task automatic push_fetch(input logic [12:0] a);
    for (int p = 0; p < PLANES; p++) exp_log.push_back({PB, 2'(p), a});
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_n"}, 32'(req_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < req_log.size(); i++)
      chk(tag, 32'(req_log[i]), 32'(exp_log[i]));
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (vdata_valid) break;
    end
  endtask

  task automatic wait_req(input logic [16:0] addr, input bit any, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_if.mem_req && (any || mem_if.mem_addr == addr)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_fetch(input logic [12:0] a, input int l);
    int n;
    lat = l;
    req_log.delete();
    exp_log.delete();
    @(negedge clk);
    vaddr = a;
    wait_valid(300, n);
    chk("latency", 32'(n), 32'(4 * (l + 2) + 1));
    chk("vdata", vdata, exp_word(a));
    push_fetch(a);
    compare_log("addr");
    cur = a;
  endtask

  // Memory responder: ack L cycles after the request first appears.
  initial begin
    int cnt;
    bit acked;
    logic [16:0] hold;
    cnt = 0; acked = 1'b0; hold = '0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_dout = 8'h00;
    forever begin
      @(negedge clk);
      mem_if.mem_ack  = 1'b0;
      mem_if.mem_dout = 8'($urandom);
      if (!reset_n) begin
        cnt = 0;
      end else if (mem_if.mem_req) begin
        if (cnt == 0) begin
          req_log.push_back(mem_if.mem_addr);
          hold  = mem_if.mem_addr;
          acked = 1'b0;
        end else if (mem_if.mem_addr !== hold || acked) begin
          viol++;
        end
        cnt++;
        if (cnt == lat + 1) begin
          mem_if.mem_ack  = 1'b1;
          mem_if.mem_dout = byte_at(int'(mem_if.mem_addr[14:13]), mem_if.mem_addr[12:0]);
          acked = 1'b1;
        end
      end else begin
        if (cnt > 0 && !acked) viol++;
        cnt = 0;
        if (spur_en && $urandom_range(0, 2) == 0) mem_if.mem_ack = 1'b1;
      end
    end
  end

  // Output monitor: record commits, late pulses and unannounced vdata changes.
  initial begin
    logic [31:0] vdata_prev;
    vdata_prev = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (fetch_late) late_seen++;
        if (vdata_valid) commits.push_back(vdata);
        else if (vdata !== vdata_prev) glitch++;
      end
      vdata_prev = vdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int late0;
    bit found;
    logic [12:0] a;
    logic [31:0] held;

    reset_n  = 1'b0;
    fetch_en = 1'b1;
    vaddr    = 13'h0000;
`ifdef VRAM_FETCH_STATS_EN
    late_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_vdata", vdata, 32'h0);
    chk("rst_valid", 32'(vdata_valid), 32'h0);
    chk("rst_req",   32'(mem_if.mem_req), 32'h0);
    chk("rst_addr",  32'(mem_if.mem_addr), 32'h0);
    chk("rst_late",  32'(fetch_late), 32'h0);

    // Reset release fetches address 0 because the state is stale.
    reset_n = 1'b1;
    wait_valid(100, n);
    chk("rel_latency", 32'(n), 32'd13);
    chk("rel_vdata", vdata, 32'h11223344);
    push_fetch(13'h0000);
    compare_log("rel_addr");
    cur = 13'h0000;

    // Steady address with stray acks: nothing may move.
    do_fetch(13'h0ABC, 1);
    req_log.delete();
    commits.delete();
    held = vdata;
    spur_en = 1'b1;
    repeat (40) @(negedge clk);
    spur_en = 1'b0;
    @(negedge clk);
    chk("steady_req", 32'(req_log.size()), 32'd0);
    chk("steady_commits", 32'(commits.size()), 32'd0);
    chk("steady_vdata", vdata, held);

    // Late change during the plane-1 handshake.
    lat = 1;
    req_log.delete(); exp_log.delete(); commits.delete();
    late0 = late_seen;
    @(negedge clk);
    vaddr = 13'h0100;
    wait_req({PB, 2'd1, 13'h0100}, 1'b0, found);
    chk("late_found", 32'(found), 32'd1);
    vaddr = 13'h0101;
    wait_valid(200, n);
    repeat (3) @(negedge clk);
    chk("late_pulses", 32'(late_seen - late0), 32'd1);
    chk("late_commits", 32'(commits.size()), 32'd1);
    if (commits.size() > 0) chk("late_word", commits[0], exp_word(13'h0101));
    exp_log.push_back({PB, 2'd0, 13'h0100});
    exp_log.push_back({PB, 2'd1, 13'h0100});
    push_fetch(13'h0101);
    compare_log("late_addr");
    cur = 13'h0101;

    // Long ack latency.
    do_fetch(13'h0777, 4);

    // fetch_en dropped during plane 2.
    lat = 1;
    req_log.delete(); exp_log.delete(); commits.delete();
    held = vdata;
    @(negedge clk);
    vaddr = 13'h1234;
    wait_req({PB, 2'd2, 13'h1234}, 1'b0, found);
    chk("dis_found", 32'(found), 32'd1);
    fetch_en = 1'b0;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 3; p++) exp_log.push_back({PB, 2'(p), 13'h1234});
    compare_log("dis_addr");
    chk("dis_commits", 32'(commits.size()), 32'd0);
    chk("dis_vdata", vdata, held);
    req_log.delete(); exp_log.delete();
    fetch_en = 1'b1;
    wait_valid(100, n);
    chk("dis_latency", 32'(n), 32'd13);
    chk("dis_vdata2", vdata, exp_word(13'h1234));
    push_fetch(13'h1234);
    compare_log("dis_refetch");
    cur = 13'h1234;

    // Random addresses and latencies, then the wrap edge.
    for (int k = 0; k < 8; k++) begin
      a = 13'($urandom);
      if (a == cur) a = a + 13'd1;
      do_fetch(a, int'($urandom_range(1, 4)));
    end
    do_fetch(13'h0555, 1);
    do_fetch(13'h1FFF, 1);
    do_fetch(13'h0000, 2);

`ifdef VRAM_FETCH_STATS_EN
    @(negedge clk); late_clr = 1'b1;
    @(negedge clk); late_clr = 1'b0;
    chk("cnt_clr0", 32'(late_count), 32'd0);
    late0 = late_seen;
    lat = 1;
    for (int k = 0; k < 3; k++) begin
      a = 13'h0200 + 13'(k * 16);
      @(negedge clk);
      vaddr = a;
      wait_req('0, 1'b1, found);
      vaddr = a ^ 13'h0001;
      wait_valid(200, n);
      chk("cnt_done", 32'(n < 200), 32'd1);
    end
    @(negedge clk);
    chk("cnt_pulses", 32'(late_seen - late0), 32'd3);
    chk("cnt_value", 32'(late_count), 32'd3);
    late_clr = 1'b1;
    @(negedge clk); late_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr", 32'(late_count), 32'd0);
    cur = a ^ 13'h0001;
`endif

    // Reset asserted in the middle of a handshake.
    lat = 3;
    @(negedge clk);
    vaddr = 13'h0F0F;
    wait_req('0, 1'b1, found);
    chk("mid_found", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_req", 32'(mem_if.mem_req), 32'd0);
    chk("mid_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("mid_vdata", vdata, 32'h0);
    @(negedge clk);
    req_log.delete(); exp_log.delete();
    lat = 1;
    reset_n = 1'b1;
    wait_valid(100, n);
    chk("mid_latency", 32'(n), 32'd13);
    chk("mid_vdata2", vdata, exp_word(13'h0F0F));
    push_fetch(13'h0F0F);
    compare_log("mid_addr2");

    repeat (3) @(negedge clk);
    chk("hs_violations", 32'(viol), 32'd0);
    chk("vdata_glitches", 32'(glitch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
